// File: rtl/uart_tx_if.sv
// Host-side write port of the UART transmitter: word, write strobe and FIFO status.
interface uart_tx_if #(
    parameter int D_W = 8
);
    logic [D_W-1:0] in_data;
    logic           wr_en;
    logic           full;
    logic           ovf;

    modport master (output in_data, output wr_en, input full, input ovf);
    modport slave  (input in_data, input wr_en, output full, output ovf);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with write FIFO; frames are start, D_W data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int D_W    = 8,
    parameter int B_TICK = 16,
    parameter int FIFO_D = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    uart_tx_if.slave      bus,
    output logic          tx,
    output logic          busy,
    output logic          done
);
    localparam int PW  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW  = PW + 1;
    localparam int TCW = (B_TICK > 1) ? $clog2(B_TICK) : 1;
    localparam int BIW = (D_W > 1) ? $clog2(D_W) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [TCW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BIW-1:0]   bit_idx_q, bit_idx_d;
    logic [D_W-1:0]   shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [D_W-1:0]   mem_q [FIFO_D];
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic full_w;
    logic push;
    logic pop;
    logic last_tick;

    assign full_w    = (count_q == CW'(FIFO_D));
    assign last_tick = tick && (tick_cnt_q == TCW'(B_TICK - 1));

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        pop        = 1'b0;
        // A write against a full FIFO is dropped even if IDLE pops this cycle.
        push       = bus.wr_en && !full_w;
        ovf_d      = bus.wr_en && full_w;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^mem_q[rd_ptr_q];
`endif
                    tick_cnt_d = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (last_tick) begin
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                    tx_d       = shift_q[0];
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (last_tick) begin
                    tick_cnt_d = '0;
                    if (bit_idx_q == BIW'(D_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_d[0];
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last_tick) begin
                    tick_cnt_d = '0;
                    state_d    = STOP;
                    tx_d       = 1'b1;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (last_tick) begin
                    tick_cnt_d = '0;
                    state_d    = IDLE;
                    tx_d       = 1'b1;
                    done_d     = 1'b1;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d   = (state_d != IDLE);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
            if (push) begin
                mem_q[wr_ptr_q] <= bus.in_data;
            end
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bus.full = full_w;
    assign bus.ovf  = ovf_q;
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter with an internal write FIFO. Accepts parallel words from the host side, serializes them LSB first as start/data/stop frames, and drives the line consumed by the `uart_rx` receiver. Shares the 16x oversampling `tick` from the baud generator.

## Interface
- `D_W`, 8: data word width.
- `B_TICK`, 16: ticks per bit period.
- `FIFO_D`, 4: FIFO depth in words; power of two, at least 2.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle baud strobe at B_TICK x baud.
- `in_data`  in  D_W  word to transmit.
- `wr_en`  in  1  push `in_data` into the FIFO.
- `full`  out  1  FIFO holds FIFO_D words.
- `ovf`  out  1  one-cycle pulse when a write is dropped.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is in progress (state != IDLE).
- `done`  out  1  one-cycle pulse at end of each stop bit.

## Operation
- Reset: `tx`=1, `busy`=0, `done`=0, `ovf`=0, `full`=0; FIFO empty; state IDLE; tick counter and bit counter cleared.
- FIFO: registered pointers and count.
  - `wr_en` with `full`=0 stores `in_data`.
  - `wr_en` with `full`=1 drops the word and pulses `ovf` next cycle, even if a pop occurs in the same cycle.
  - `full` reflects count after the edge.
- States:
  - IDLE: `tx`=1. If FIFO non-empty, pop the head into the shift register, clear the tick counter, go to START.
  - START: `tx`=0. On each `tick`, increment the counter. On the tick where the counter reaches B_TICK-1, clear the counter and bit index, then go to DATA.
  - DATA: `tx`=shift[0]. On the B_TICK-th tick, shift right by one and increment the bit index. After bit D_W-1, go to PARITY (if the macro is defined) or STOP.
  - PARITY: `tx`=even parity of the popped word. Lasts B_TICK ticks, then goes to STOP.
  - STOP: `tx`=1. On the B_TICK-th tick, go to IDLE and pulse `done` for one cycle.
- `tx` is registered; it changes only on the clock edge that changes state or shifts.
- Bit-index width is clog2(D_W); tick-counter width is clog2(B_TICK). Both wrap only through explicit clears.
- The FIFO is never popped outside IDLE. Writes are accepted in any state.
- Reset mid-frame aborts the frame: `tx`=1 on the next edge, FIFO flushed, no `done` pulse.

## Timing
- Frame start: a write into an empty FIFO while IDLE:
  - edge N stores the word;
  - edge N+1 pops it and enters START;
  - `tx` goes low after edge N+1.
- Start-bit duration is B_TICK ticks, counted from the first `tick` seen in START. Each subsequent bit is exactly B_TICK ticks.
- Back-to-back frames: after `done`, one clock in IDLE (`tx`=1), then the next frame starts. The stop bit is never shortened.
- `busy` rises with the START entry edge and falls with the `done` edge.
- `tick` asserted on the same cycle as the IDLE-to-START transition is not counted.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state is compiled in;
  - frames are 1 + D_W + 1 + 1 bits, with even parity (XOR of data bits).
- Undefined:
  - no PARITY state, no parity logic;
  - frames are 1 + D_W + 1 bits.

## Test plan
- Single word, D_W=8, B_TICK=16, `tick` every 4 clocks, write 0xA5 -> `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks; `done` pulses once; `busy` low afterward.
- Back-to-back: write 0x00 and 0xFF on consecutive cycles -> two frames separated by exactly one IDLE clock; 2 `done` pulses.
- Overflow, FIFO_D=4: write 6 words while the first frame is in progress -> first word popped, next 4 stored; 6th write while `full`=1 gives one `ovf` pulse. Exactly 5 frames are sent, and the dropped word never appears.
- Parity build, write 0x07 (three ones) -> parity bit 1; write 0xA5 -> parity bit 0; frame length 11 bits.
- Reset during DATA bit 3 -> `tx`=1 on the next edge, `full`=0, no `done` pulse; a new write after reset transmits normally.
- Loopback: `tx` wired to `uart_rx` with a shared `tick`, send 0x3C -> receiver `out_data`=0x3C after its stop state.
